mesif_line_ctrl: RTL and testbench

MESIF_LINE_CTRL -- requirements
Module: mesif_line_ctrl

---
 rtl/mesif_pkg.sv | 96 +++++++++
 rtl/mesif_state_array.sv | 32 +++
 rtl/mesif_line_ctrl.sv | 172 +++++++++++++++++
 tb/tb_mesif_line_ctrl.sv | 229 ++++++++++++++++++++++
 4 files changed

// File: rtl/mesif_pkg.sv
// MESIF line controller: shared encodings and the line next-state function.
package mesif_pkg;

  typedef enum logic [2:0] {
    ST_M = 3'd0,
    ST_E = 3'd1,
    ST_S = 3'd2,
    ST_I = 3'd3,
    ST_F = 3'd4
  } line_state_e;

  typedef enum logic [3:0] {
    OP_L1D_RD   = 4'd0,
    OP_L1D_WR   = 4'd1,
    OP_L1I_RD   = 4'd2,
    OP_SNP_INV  = 4'd3,
    OP_SNP_RD   = 4'd4,
    OP_SNP_WR   = 4'd5,
    OP_SNP_RWIM = 4'd6,
    OP_CLEAR    = 4'd8,
    OP_PRINT    = 4'd9
  } op_e;

  typedef enum logic [2:0] {
    BUS_NONE  = 3'd0,
    BUS_READ  = 3'd1,
    BUS_WRITE = 3'd2,
    BUS_INV   = 3'd3,
    BUS_RWIM  = 3'd4
  } bus_op_e;

  typedef enum logic [1:0] {
    SNP_NOHIT = 2'd0,
    SNP_HIT   = 2'd1,
    SNP_HITM  = 2'd2
  } snoop_e;

  typedef struct packed {
    line_state_e nxt;
    bus_op_e     bus_op;
    snoop_e      snoop;
  } line_upd_t;

  // Line transition for one op. A tag miss behaves as Invalid. The bus snoop
  // result only matters for the READ fill (HIT/HITM -> F, otherwise E).
  function automatic line_upd_t next_state(input logic [3:0] op, input line_state_e cur,
                                           input logic hit, input logic [1:0] bus_snoop);
    line_state_e eff;
    line_upd_t   upd;
    eff        = hit ? cur : ST_I;
    upd.nxt    = cur;
    upd.bus_op = BUS_NONE;
    upd.snoop  = SNP_NOHIT;
    case (op)
      OP_L1D_RD, OP_L1I_RD: begin
        if (eff == ST_I) begin
          upd.bus_op = BUS_READ;
          upd.nxt    = (bus_snoop == 2'd1 || bus_snoop == 2'd2) ? ST_F : ST_E;
        end else begin
          upd.nxt = cur;
        end
      end
      OP_L1D_WR: begin
        case (eff)
          ST_M, ST_E: upd.nxt = ST_M;
          ST_S, ST_F: begin upd.nxt = ST_M; upd.bus_op = BUS_INV;  end
          default:    begin upd.nxt = ST_M; upd.bus_op = BUS_RWIM; end
        endcase
      end
      OP_SNP_RD: begin
        case (eff)
          ST_M:             begin upd.nxt = ST_S; upd.snoop = SNP_HITM; upd.bus_op = BUS_WRITE; end
          ST_E, ST_S, ST_F: begin upd.nxt = ST_S; upd.snoop = SNP_HIT; end
          default:          upd.snoop = SNP_NOHIT;
        endcase
      end
      OP_SNP_INV: begin
        if (eff == ST_S || eff == ST_F) begin
          upd.nxt = ST_I;
        end else begin
          upd.nxt = cur;
        end
      end
      OP_SNP_RWIM: begin
        case (eff)
          ST_M:             begin upd.nxt = ST_I; upd.snoop = SNP_HITM; upd.bus_op = BUS_WRITE; end
          ST_E, ST_S, ST_F: begin upd.nxt = ST_I; upd.snoop = SNP_HIT; end
          default:          upd.snoop = SNP_NOHIT;
        endcase
      end
      default: upd.nxt = cur;
    endcase
    return upd;
  endfunction

endpackage

// File: rtl/mesif_state_array.sv
// Per-line MESIF state storage: one async read port, one write port, reset to I.
module mesif_state_array
  import mesif_pkg::*;
#(
  parameter int DEPTH = 131072,
  parameter int IDX_W = 17
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic [IDX_W-1:0] rd_idx,
  output line_state_e      rd_state,
  input  logic             wr_en,
  input  logic [IDX_W-1:0] wr_idx,
  input  line_state_e      wr_state
);

  line_state_e mem_r [DEPTH];

  // Line state update; every line returns to Invalid on reset.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < DEPTH; i++) begin
        mem_r[i] <= ST_I;
      end
    end else if (wr_en) begin
      mem_r[wr_idx] <= wr_state;
    end
  end

  assign rd_state = mem_r[rd_idx];

endmodule

// File: rtl/mesif_line_ctrl.sv
// MESIF cache line controller: accepts CPU/snoop ops, drives the bus, updates line state.
module mesif_line_ctrl
  import mesif_pkg::*;
#(
  parameter int SETS     = 16384,
  parameter int WAYS     = 8,
  parameter int OPR_BITS = 4
) (
  input  logic                    clk,
  input  logic                    rst_n,
  input  logic                    req_valid,
  output logic                    req_ready,
  input  logic [OPR_BITS-1:0]     req_op,
  input  logic [$clog2(SETS)-1:0] req_set,
  input  logic [$clog2(WAYS)-1:0] req_way,
  input  logic                    req_hit,
  output logic                    bus_valid,
  output logic [2:0]              bus_op,
  input  logic                    bus_ack,
  input  logic [1:0]              bus_snoop_in,
  output logic                    rsp_valid,
  output logic [1:0]              rsp_snoop,
  output logic [2:0]              rsp_state
);

  localparam int SET_W = $clog2(SETS);
  localparam int WAY_W = $clog2(WAYS);
  localparam int IDX_W = SET_W + WAY_W;
  localparam int DEPTH = SETS * WAYS;
  localparam logic [IDX_W-1:0] CLR_LAST = IDX_W'(DEPTH - 1);

  typedef enum logic [1:0] {
    S_IDLE  = 2'd0,
    S_BUS   = 2'd1,
    S_DONE  = 2'd2,
    S_CLEAR = 2'd3
  } fsm_e;

  fsm_e        fsm_r;
  logic [3:0]  op_r;
  logic [IDX_W-1:0] idx_r;
  logic [IDX_W-1:0] clr_cnt_r;
  logic        hit_r;
  logic        bus_valid_r;
  bus_op_e     bus_op_r;
  logic        rsp_valid_r;
  snoop_e      rsp_snoop_r;
  line_state_e rsp_state_r;

  logic        idle_s;
  logic [3:0]  op_s;
  logic        hit_s;
  logic [1:0]  snp_s;
  logic [IDX_W-1:0] rd_idx_s;
  logic [IDX_W-1:0] wr_idx_s;
  line_state_e rd_state_s;
  line_state_e wr_state_s;
  logic        wr_en_s;
  line_upd_t   upd_s;

  // In IDLE the live request is evaluated; otherwise the captured one is.
  always_comb begin
    idle_s   = (fsm_r == S_IDLE);
    op_s     = idle_s ? req_op[3:0] : op_r;
    hit_s    = idle_s ? req_hit : hit_r;
    rd_idx_s = idle_s ? {req_set, req_way} : idx_r;
    snp_s    = (fsm_r == S_BUS) ? bus_snoop_in : 2'd0;
    upd_s    = next_state(op_s, rd_state_s, hit_s, snp_s);
  end

  // Array write: no-bus ops at acceptance, bus ops on ack, clear sweeps all lines.
  always_comb begin
    wr_en_s    = 1'b0;
    wr_idx_s   = rd_idx_s;
    wr_state_s = upd_s.nxt;
    case (fsm_r)
      S_IDLE:  wr_en_s = req_valid && (op_s != OP_CLEAR) && (upd_s.bus_op == BUS_NONE);
      S_BUS:   wr_en_s = bus_ack;
      S_CLEAR: begin
        wr_en_s    = 1'b1;
        wr_idx_s   = clr_cnt_r;
        wr_state_s = ST_I;
      end
      default: wr_en_s = 1'b0;
    endcase
  end

  mesif_state_array #(
    .DEPTH (DEPTH),
    .IDX_W (IDX_W)
  ) u_array (
    .clk      (clk),
    .rst_n    (rst_n),
    .rd_idx   (rd_idx_s),
    .rd_state (rd_state_s),
    .wr_en    (wr_en_s),
    .wr_idx   (wr_idx_s),
    .wr_state (wr_state_s)
  );

  // Control FSM with registered bus and response outputs.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      fsm_r       <= S_IDLE;
      op_r        <= 4'd0;
      idx_r       <= '0;
      hit_r       <= 1'b0;
      clr_cnt_r   <= '0;
      bus_valid_r <= 1'b0;
      bus_op_r    <= BUS_NONE;
      rsp_valid_r <= 1'b0;
      rsp_snoop_r <= SNP_NOHIT;
      rsp_state_r <= ST_I;
    end else begin
      case (fsm_r)
        S_IDLE: begin
          rsp_valid_r <= 1'b0;
          if (req_valid) begin
            op_r  <= op_s;
            idx_r <= rd_idx_s;
            hit_r <= req_hit;
            if (op_s == OP_CLEAR) begin
              clr_cnt_r <= '0;
              fsm_r     <= S_CLEAR;
            end else if (upd_s.bus_op != BUS_NONE) begin
              bus_valid_r <= 1'b1;
              bus_op_r    <= upd_s.bus_op;
              fsm_r       <= S_BUS;
            end else begin
              rsp_valid_r <= 1'b1;
              rsp_state_r <= upd_s.nxt;
              rsp_snoop_r <= upd_s.snoop;
              fsm_r       <= S_DONE;
            end
          end
        end
        S_BUS: begin
          if (bus_ack) begin
            bus_valid_r <= 1'b0;
            bus_op_r    <= BUS_NONE;
            rsp_valid_r <= 1'b1;
            rsp_state_r <= upd_s.nxt;
            rsp_snoop_r <= upd_s.snoop;
            fsm_r       <= S_DONE;
          end
        end
        S_CLEAR: begin
          clr_cnt_r <= clr_cnt_r + 1'b1;
          if (clr_cnt_r == CLR_LAST) begin
            rsp_valid_r <= 1'b1;
            rsp_state_r <= ST_I;
            rsp_snoop_r <= SNP_NOHIT;
            fsm_r       <= S_DONE;
          end
        end
        S_DONE: begin
          rsp_valid_r <= 1'b0;
          fsm_r       <= S_IDLE;
        end
        default: fsm_r <= S_IDLE;
      endcase
    end
  end

  assign req_ready = (fsm_r == S_IDLE);
  assign bus_valid = bus_valid_r;
  assign bus_op    = bus_op_r;
  assign rsp_valid = rsp_valid_r;
  assign rsp_snoop = rsp_snoop_r;
  assign rsp_state = rsp_state_r;

endmodule

// File: tb/tb_mesif_line_ctrl.sv
// Self-checking bench for mesif_line_ctrl: scoreboard of expected responses.
module tb_mesif_line_ctrl;

  localparam logic [2:0] LM = 3'd0, LE = 3'd1, LS = 3'd2, LI = 3'd3, LF = 3'd4;
  localparam logic [2:0] B_NONE = 3'd0, B_RD = 3'd1, B_WR = 3'd2, B_INV = 3'd3, B_RWIM = 3'd4;
  localparam logic [1:0] NOHIT = 2'd0, HIT = 2'd1, HITM = 2'd2;

  logic       clk = 1'b0;
  logic       rst_n, req_valid, tgt, req_hit, bus_ack;
  logic [3:0] req_op;
  logic [2:0] req_set;
  logic [1:0] req_way;
  logic [1:0] bus_snoop_in;

  logic a_req_ready, a_bus_valid, a_rsp_valid;
  logic [2:0] a_bus_op, a_rsp_state;
  logic [1:0] a_rsp_snoop;
  logic c_req_ready, c_bus_valid, c_rsp_valid;
  logic [2:0] c_bus_op, c_rsp_state;
  logic [1:0] c_rsp_snoop;

  logic m_req_ready, m_bus_valid, m_rsp_valid;
  logic [2:0] m_bus_op, m_rsp_state;
  logic [1:0] m_rsp_snoop;

  always #5 clk = ~clk;

  mesif_line_ctrl #(.SETS(8), .WAYS(4), .OPR_BITS(4)) dut_a (
    .clk(clk), .rst_n(rst_n), .req_valid(req_valid & ~tgt), .req_ready(a_req_ready),
    .req_op(req_op), .req_set(req_set), .req_way(req_way), .req_hit(req_hit),
    .bus_valid(a_bus_valid), .bus_op(a_bus_op), .bus_ack(bus_ack), .bus_snoop_in(bus_snoop_in),
    .rsp_valid(a_rsp_valid), .rsp_snoop(a_rsp_snoop), .rsp_state(a_rsp_state));

  mesif_line_ctrl #(.SETS(4), .WAYS(2), .OPR_BITS(4)) dut_c (
    .clk(clk), .rst_n(rst_n), .req_valid(req_valid & tgt), .req_ready(c_req_ready),
    .req_op(req_op), .req_set(req_set[1:0]), .req_way(req_way[0]), .req_hit(req_hit),
    .bus_valid(c_bus_valid), .bus_op(c_bus_op), .bus_ack(bus_ack), .bus_snoop_in(bus_snoop_in),
    .rsp_valid(c_rsp_valid), .rsp_snoop(c_rsp_snoop), .rsp_state(c_rsp_state));

  assign m_req_ready = tgt ? c_req_ready : a_req_ready;
  assign m_bus_valid = tgt ? c_bus_valid : a_bus_valid;
  assign m_bus_op    = tgt ? c_bus_op    : a_bus_op;
  assign m_rsp_valid = tgt ? c_rsp_valid : a_rsp_valid;
  assign m_rsp_state = tgt ? c_rsp_state : a_rsp_state;
  assign m_rsp_snoop = tgt ? c_rsp_snoop : a_rsp_snoop;

  typedef struct {
    logic [2:0] st;
    logic [1:0] sn;
  } exp_t;

  exp_t exp_q[$];
  exp_t mon_e;
  int   n_tests = 0;
  int   n_fail  = 0;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0d expected %0d", tag, got, exp);
    end
  endtask

  // Response monitor: every rsp_valid pulse must match the oldest expectation.
  always @(negedge clk) begin
    if (rst_n && m_rsp_valid) begin
      if (exp_q.size() == 0) begin
        chk("rsp_without_request", {31'd0, m_rsp_valid}, 32'd0);
      end else begin
        mon_e = exp_q.pop_front();
        chk("rsp_state", {29'd0, m_rsp_state}, {29'd0, mon_e.st});
        chk("rsp_snoop", {30'd0, m_rsp_snoop}, {30'd0, mon_e.sn});
      end
    end
  end

  task automatic wait_ready();
    int k;
    k = 0;
    while (!m_req_ready && k < 20) begin
      @(negedge clk);
      k++;
    end
    chk("ready_timeout", {31'd0, m_req_ready}, 32'd1);
  endtask

  task automatic do_req(input logic [3:0] op, input logic [2:0] set, input logic [1:0] way,
                        input logic hit, input logic [2:0] exp_bus, input logic [1:0] snp,
                        input logic [2:0] exp_st, input logic [1:0] exp_sn);
    @(negedge clk);
    wait_ready();
    req_valid = 1'b1; req_op = op; req_set = set; req_way = way; req_hit = hit;
    if (exp_bus == B_NONE) exp_q.push_back('{st: exp_st, sn: exp_sn});
    @(posedge clk);
    @(negedge clk);
    req_valid = 1'b0; req_op = 4'd1;
    req_set = 3'($urandom); req_way = 2'($urandom); req_hit = 1'($urandom);
    if (exp_bus == B_NONE) begin
      chk("nobus_rsp_latency", {31'd0, m_rsp_valid}, 32'd1);
      chk("nobus_bus_valid", {31'd0, m_bus_valid}, 32'd0);
    end else begin
      chk("bus_valid", {31'd0, m_bus_valid}, 32'd1);
      chk("bus_op", {29'd0, m_bus_op}, {29'd0, exp_bus});
      chk("bus_early_rsp", {31'd0, m_rsp_valid}, 32'd0);
      // A new request while busy must be ignored.
      req_valid = 1'b1; req_op = 4'd8; bus_snoop_in = HIT;
      repeat (2) @(negedge clk);
      chk("bus_valid_hold", {31'd0, m_bus_valid}, 32'd1);
      chk("bus_op_hold", {29'd0, m_bus_op}, {29'd0, exp_bus});
      req_valid = 1'b0; bus_ack = 1'b1; bus_snoop_in = snp;
      exp_q.push_back('{st: exp_st, sn: exp_sn});
      @(negedge clk);
      bus_ack = 1'b0; bus_snoop_in = NOHIT;
      chk("bus_rsp_latency", {31'd0, m_rsp_valid}, 32'd1);
      chk("bus_released", {31'd0, m_bus_valid}, 32'd0);
    end
  endtask

  initial begin
    #300000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    int lat, ready_hi;
    rst_n = 1'b0; req_valid = 1'b0; tgt = 1'b0; req_hit = 1'b0; bus_ack = 1'b0;
    req_op = 4'd0; req_set = 3'd0; req_way = 2'd0; bus_snoop_in = 2'd0;
    repeat (3) @(negedge clk);
    rst_n = 1'b1;
    #1;
    chk("rst_ready", {31'd0, a_req_ready}, 32'd1);
    chk("rst_bus_valid", {31'd0, a_bus_valid}, 32'd0);
    chk("rst_bus_op", {29'd0, a_bus_op}, {29'd0, B_NONE});
    chk("rst_rsp_valid", {31'd0, a_rsp_valid}, 32'd0);
    chk("rst_rsp_state", {29'd0, a_rsp_state}, {29'd0, LI});
    chk("rst_rsp_snoop", {30'd0, a_rsp_snoop}, {30'd0, NOHIT});
    chk("rst_ready_c", {31'd0, c_req_ready}, 32'd1);

    // CPU reads, snoops and writes on dut_a
    do_req(4'd0, 3'd5, 2'd2, 1'b1, B_RD,   NOHIT, LE, NOHIT);
    do_req(4'd9, 3'd5, 2'd2, 1'b1, B_NONE, NOHIT, LE, NOHIT);
    do_req(4'd2, 3'd5, 2'd2, 1'b1, B_NONE, NOHIT, LE, NOHIT);
    do_req(4'd0, 3'd1, 2'd0, 1'b0, B_RD,   HITM,  LF, NOHIT);
    do_req(4'd3, 3'd1, 2'd0, 1'b1, B_NONE, NOHIT, LI, NOHIT);
    do_req(4'd2, 3'd1, 2'd0, 1'b1, B_RD,   HIT,   LF, NOHIT);
    do_req(4'd0, 3'd1, 2'd0, 1'b1, B_NONE, NOHIT, LF, NOHIT);
    do_req(4'd4, 3'd1, 2'd0, 1'b1, B_NONE, NOHIT, LS, HIT);
    do_req(4'd1, 3'd1, 2'd0, 1'b1, B_INV,  HITM,  LM, NOHIT);
    do_req(4'd1, 3'd1, 2'd0, 1'b1, B_NONE, NOHIT, LM, NOHIT);
    do_req(4'd4, 3'd1, 2'd0, 1'b1, B_WR,   HIT,   LS, HITM);
    do_req(4'd1, 3'd2, 2'd3, 1'b0, B_RWIM, NOHIT, LM, NOHIT);
    do_req(4'd6, 3'd2, 2'd3, 1'b1, B_WR,   NOHIT, LI, HITM);
    do_req(4'd1, 3'd3, 2'd1, 1'b0, B_RWIM, NOHIT, LM, NOHIT);
    do_req(4'd5, 3'd3, 2'd1, 1'b1, B_NONE, NOHIT, LM, NOHIT);
    do_req(4'd6, 3'd5, 2'd2, 1'b1, B_NONE, NOHIT, LI, HIT);
    do_req(4'd4, 3'd0, 2'd0, 1'b0, B_NONE, NOHIT, LI, NOHIT);
    do_req(4'd7, 3'd3, 2'd1, 1'b1, B_NONE, NOHIT, LM, NOHIT);
    do_req(4'd12, 3'd3, 2'd1, 1'b1, B_NONE, NOHIT, LM, NOHIT);
    do_req(4'd0, 3'd6, 2'd0, 1'b0, B_RD,   NOHIT, LE, NOHIT);
    do_req(4'd1, 3'd6, 2'd0, 1'b1, B_NONE, NOHIT, LM, NOHIT);
    do_req(4'd3, 3'd6, 2'd0, 1'b1, B_NONE, NOHIT, LM, NOHIT);

    // bus_ack while idle must be ignored
    @(negedge clk);
    bus_ack = 1'b1; bus_snoop_in = HITM;
    @(negedge clk);
    bus_ack = 1'b0; bus_snoop_in = NOHIT;
    chk("stray_ack_bus_valid", {31'd0, m_bus_valid}, 32'd0);
    chk("stray_ack_ready", {31'd0, m_req_ready}, 32'd1);

    // Reset in the middle of a bus operation
    do_req(4'd0, 3'd4, 2'd0, 1'b0, B_RD, NOHIT, LE, NOHIT);
    @(negedge clk);
    wait_ready();
    req_valid = 1'b1; req_op = 4'd1; req_set = 3'd4; req_way = 2'd1; req_hit = 1'b0;
    @(posedge clk);
    @(negedge clk);
    req_valid = 1'b0;
    chk("abort_bus_valid_pre", {31'd0, m_bus_valid}, 32'd1);
    rst_n = 1'b0;
    #1;
    chk("abort_bus_valid_async", {31'd0, m_bus_valid}, 32'd0);
    chk("abort_bus_op_async", {29'd0, m_bus_op}, {29'd0, B_NONE});
    @(negedge clk);
    rst_n = 1'b1;
    #1;
    chk("abort_ready_after_release", {31'd0, m_req_ready}, 32'd1);
    repeat (3) @(negedge clk);
    chk("abort_no_rsp", {31'd0, m_rsp_valid}, 32'd0);
    do_req(4'd9, 3'd4, 2'd0, 1'b1, B_NONE, NOHIT, LI, NOHIT);

    // Clear on the small instance (4 sets x 2 ways)
    @(negedge clk);
    tgt = 1'b1;
    do_req(4'd1, 3'd2, 2'd1, 1'b0, B_RWIM, NOHIT, LM, NOHIT);
    do_req(4'd0, 3'd3, 2'd0, 1'b0, B_RD,   NOHIT, LE, NOHIT);
    @(negedge clk);
    wait_ready();
    req_valid = 1'b1; req_op = 4'd8; req_set = 3'd0; req_way = 2'd0; req_hit = 1'b1;
    exp_q.push_back('{st: LI, sn: NOHIT});
    @(posedge clk);
    lat = 0;
    ready_hi = 0;
    for (int k = 1; k <= 40; k++) begin
      @(negedge clk);
      req_valid = 1'b0;
      if (m_rsp_valid) begin
        lat = k;
        break;
      end
      if (m_req_ready) ready_hi++;
    end
    chk("clear_latency", lat, 32'd9);
    chk("clear_ready_low", ready_hi, 32'd0);
    for (int s = 0; s < 4; s++) begin
      for (int w = 0; w < 2; w++) begin
        do_req(4'd9, 3'(s), 2'(w), 1'b1, B_NONE, NOHIT, LI, NOHIT);
      end
    end

    repeat (3) @(negedge clk);
    chk("scoreboard_drained", exp_q.size(), 32'd0);
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
